video_out_stream_gen: RTL and testbench

//  Parametrised video output timing generator and FIFO drain; single clock domain.

---
 rtl/video_pkg.sv | 11 +
 rtl/video_tick_counter.sv | 19 +
 rtl/video_out_stream_gen.sv | 126 ++++++++++++
 tb/tb_video_out_stream_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg: shared state encoding, default timing and counter width helper for the video output generator
package video_pkg;
  typedef enum logic [1:0] {IDLE, VBLANK, ACTIVE, HBLANK} state_t;
  localparam int DEF_WIDTH  = 640;
  localparam int DEF_HEIGHT = 480;
  localparam int DEF_HBLANK = 50;
  localparam int DEF_VBLANK = 100;
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/video_tick_counter.sv
// video_tick_counter: enabled up-counter with synchronous clear, clear has priority
module video_tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  // next count: clear wins over increment
  always_comb cnt_d = clr ? '0 : inc ? cnt_q + 1'b1 : cnt_q;
  // count register
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/video_out_stream_gen.sv
// video_out_stream_gen: pix_en-paced video timing generator draining a show-ahead FIFO, with test pattern and underflow flag
module video_out_stream_gen
  import video_pkg::*;
#(
  parameter int P_WIDTH     = DEF_WIDTH,
  parameter int P_HEIGHT    = DEF_HEIGHT,
  parameter int P_HBLANK    = DEF_HBLANK,
  parameter int P_VBLANK    = DEF_VBLANK,
  parameter int P_DW        = 8,
  parameter int P_START_LVL = 16,
  parameter int P_LVL_W     = 8
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               pix_en,
  input  logic               en,
  input  logic               pattern_mode,
  input  logic               clr_status,
  input  logic [P_DW-1:0]    fifo_data,
  input  logic               fifo_empty,
  input  logic [P_LVL_W-1:0] fifo_level,
  output logic               rd_en,
  output logic [P_DW-1:0]    pixel_out,
  output logic               frame_valid,
  output logic               line_valid,
  output logic               sof,
  output logic               underflow
);
  localparam int HW = cnt_w(P_WIDTH);
  localparam int VW = cnt_w(P_HEIGHT);
  localparam int BW = cnt_w(P_HBLANK > P_VBLANK ? P_HBLANK : P_VBLANK);
  localparam int SW = HW + VW;
  state_t            state_q, state_d;
  logic              pat_q, pat_d;
  logic              line_valid_q, line_valid_d, frame_valid_q, frame_valid_d;
  logic              sof_q, sof_d, underflow_q, underflow_d;
  logic [P_DW-1:0]   pixel_q, pixel_d, px;
  logic [HW-1:0]     hcnt;
  logic [VW-1:0]     vcnt;
  logic [BW-1:0]     bcnt;
  logic [SW-1:0]     pat_sum;
  logic              h_inc, h_clr, v_inc, v_clr, b_inc, b_clr;
  logic              h_last, v_last, vb_last, hb_last, go, active, tick_act;
  video_tick_counter #(.W(HW)) u_hcnt (.clk(clk), .nRST(nRST), .inc(h_inc), .clr(h_clr), .cnt(hcnt));
  video_tick_counter #(.W(VW)) u_vcnt (.clk(clk), .nRST(nRST), .inc(v_inc), .clr(v_clr), .cnt(vcnt));
  video_tick_counter #(.W(BW)) u_bcnt (.clk(clk), .nRST(nRST), .inc(b_inc), .clr(b_clr), .cnt(bcnt));
  assign h_last   = hcnt == HW'(P_WIDTH - 1);
  assign v_last   = vcnt == VW'(P_HEIGHT - 1);
  assign vb_last  = bcnt == BW'(P_VBLANK - 1);
  assign hb_last  = bcnt == BW'(P_HBLANK - 1);
  assign go       = pattern_mode | (fifo_level >= P_LVL_W'(P_START_LVL));
  assign active   = state_q == ACTIVE;
  assign tick_act = pix_en & active;
  assign pat_sum  = SW'(hcnt) + SW'(vcnt);
  assign px       = pat_q ? P_DW'(pat_sum) : fifo_empty ? '0 : fifo_data;
  assign rd_en    = tick_act & ~pat_q & ~fifo_empty;
  // frame sequencing and counter control, only moves on pix_en ticks
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    h_inc   = 1'b0;
    h_clr   = 1'b0;
    v_inc   = 1'b0;
    v_clr   = 1'b0;
    b_inc   = 1'b0;
    b_clr   = 1'b0;
    if (pix_en)
      case (state_q)
        IDLE: if (en) begin
          state_d = VBLANK;
          b_clr   = 1'b1;
        end
        VBLANK: if (!vb_last) b_inc = 1'b1;
          else if (go) begin
            state_d = ACTIVE;
            h_clr   = 1'b1;
            v_clr   = 1'b1;
            pat_d   = pattern_mode;
          end
        ACTIVE: if (!h_last) h_inc = 1'b1;
          else begin
            state_d = !v_last ? HBLANK : en ? VBLANK : IDLE;
            b_clr   = 1'b1;
          end
        HBLANK: if (!hb_last) b_inc = 1'b1;
          else begin
            state_d = ACTIVE;
            h_clr   = 1'b1;
            v_inc   = 1'b1;
          end
        default: state_d = IDLE;
      endcase
  end
  // registered outputs lag the state by one tick; underflow set beats clear
  always_comb begin
    line_valid_d  = pix_en ? active : line_valid_q;
    frame_valid_d = pix_en ? (active | state_q == HBLANK) : frame_valid_q;
    sof_d         = tick_act & hcnt == '0 & vcnt == '0;
    pixel_d       = tick_act ? px : pixel_q;
    underflow_d   = (tick_act & ~pat_q & fifo_empty) | (underflow_q & ~clr_status);
  end
  // state and output registers
  always_ff @(posedge clk or negedge nRST)
    if (!nRST) begin
      state_q       <= IDLE;
      pat_q         <= 1'b0;
      line_valid_q  <= 1'b0;
      frame_valid_q <= 1'b0;
      sof_q         <= 1'b0;
      pixel_q       <= '0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pat_q         <= pat_d;
      line_valid_q  <= line_valid_d;
      frame_valid_q <= frame_valid_d;
      sof_q         <= sof_d;
      pixel_q       <= pixel_d;
      underflow_q   <= underflow_d;
    end
  assign line_valid  = line_valid_q;
  assign frame_valid = frame_valid_q;
  assign sof         = sof_q;
  assign pixel_out   = pixel_q;
  assign underflow   = underflow_q;
endmodule

// File: tb/tb_video_out_stream_gen.sv
// tb_video_out_stream_gen: scenario table plus scoreboard of expected pixels for a 4x3 frame
module tb_video_out_stream_gen;
  localparam int W = 4, H = 3, HB = 2, VB = 3, SL = 4;
  logic clk = 0, nRST = 0, pix_en = 0, en = 0, pattern_mode = 0, clr_status = 0;
  logic [7:0] fifo_data, fifo_level, pixel_out;
  logic fifo_empty, rd_en, frame_valid, line_valid, sof, underflow;
  video_out_stream_gen #(
    .P_WIDTH(W), .P_HEIGHT(H), .P_HBLANK(HB), .P_VBLANK(VB),
    .P_DW(8), .P_START_LVL(SL), .P_LVL_W(8)
  ) dut (
    .clk(clk), .nRST(nRST), .pix_en(pix_en), .en(en), .pattern_mode(pattern_mode),
    .clr_status(clr_status), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_level(fifo_level), .rd_en(rd_en), .pixel_out(pixel_out),
    .frame_valid(frame_valid), .line_valid(line_valid), .sof(sof), .underflow(underflow)
  );
  always #5 clk = ~clk;
  typedef struct { logic [7:0] px; logic sf; logic uf; } exp_t;
  typedef struct { int per; int words; bit pat; int exp_rd; bit exp_uf; int exp_left; } scen_t;
  exp_t exp_q[$];
  exp_t e, e_push;
  logic [7:0] fifo_q[$];
  scen_t tbl[5];
  scen_t c;
  int checks = 0, errors = 0;
  int rd_cnt = 0, fv_cnt = 0, lv_cnt = 0, bursts = 0, npix = 0;
  logic sb_on = 0, rd_seen = 0, pix_prev = 0, lv_prev = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  task automatic upd();
    fifo_data  = fifo_q.size() > 0 ? fifo_q[0] : 8'h00;
    fifo_empty = fifo_q.size() == 0;
    fifo_level = 8'(fifo_q.size());
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    sb_on = 0;
    nRST = 0;
    en = 0;
    pix_en = 0;
    pattern_mode = 0;
    clr_status = 0;
    fifo_q.delete();
    exp_q.delete();
    upd();
    repeat (2) step();
    nRST = 1;
    step();
  endtask

  // show-ahead FIFO model: pops the word the DUT consumed on this edge
  always @(posedge clk) begin
    #1;
    if (rd_seen && nRST && fifo_q.size() > 0) void'(fifo_q.pop_front());
    upd();
  end

  // monitor: mid-cycle sampling, scoreboard compare on every newly emitted pixel
  always @(negedge clk) begin
    rd_seen = rd_en;
    chk("rd_en_without_pix_en", rd_en & ~pix_en, 0);
    if (sb_on) begin
      if (pix_prev && line_valid) begin
        npix++;
        chk("pixel_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pixel_out", pixel_out, e.px);
          chk("sof", sof, e.sf);
          chk("underflow", underflow, e.uf);
        end
      end else chk("sof_stray", sof, 0);
      if (rd_en) rd_cnt++;
      if (frame_valid) fv_cnt++;
      if (line_valid) lv_cnt++;
      if (line_valid && !lv_prev) bursts++;
    end
    lv_prev = line_valid;
    pix_prev = pix_en;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, tail, i, got_sof;
    tbl[0] = '{1, 12, 1'b0, 12, 1'b0, 0};
    tbl[1] = '{3, 12, 1'b0, 12, 1'b0, 0};
    tbl[2] = '{1, 5, 1'b0, 5, 1'b1, 0};
    tbl[3] = '{1, 0, 1'b1, 0, 1'b0, 0};
    tbl[4] = '{2, 12, 1'b1, 0, 1'b0, 12};
    upd();
    do_reset();
    chk("rst_rd_en", rd_en, 0);
    chk("rst_pixel_out", pixel_out, 0);
    chk("rst_frame_valid", frame_valid, 0);
    chk("rst_line_valid", line_valid, 0);
    chk("rst_sof", sof, 0);
    chk("rst_underflow", underflow, 0);
    for (int s = 0; s < 5; s++) begin
      c = tbl[s];
      do_reset();
      for (int n = 1; n <= c.words; n++) fifo_q.push_back(8'(n));
      upd();
      pattern_mode = c.pat;
      for (int v = 0; v < H; v++)
        for (int h = 0; h < W; h++) begin
          i = v * W + h;
          e_push.px = c.pat ? 8'(h + v) : (i < c.words ? 8'(i + 1) : 8'd0);
          e_push.sf = (i == 0);
          e_push.uf = !c.pat && i >= c.words;
          exp_q.push_back(e_push);
        end
      rd_cnt = 0; fv_cnt = 0; lv_cnt = 0; bursts = 0; npix = 0;
      sb_on = 1;
      en = 1;
      k = 0;
      tail = 0;
      while (k < 600 && tail < 12 * c.per) begin
        step();
        pix_en = (k % c.per) == c.per - 1;
        if (npix >= 5) en = 0;
        if (exp_q.size() == 0 && !frame_valid && !line_valid) tail++;
        k++;
      end
      pix_en = 0;
      step();
      sb_on = 0;
      chk("frame_timeout", k < 600, 1);
      chk("rd_count", rd_cnt, c.exp_rd);
      chk("frame_valid_clks", fv_cnt, 16 * c.per);
      chk("line_valid_clks", lv_cnt, 12 * c.per);
      chk("line_bursts", bursts, 3);
      chk("pixels_missing", exp_q.size(), 0);
      chk("fifo_words_left", fifo_q.size(), c.exp_left);
      chk("idle_frame_valid", frame_valid, 0);
      chk("underflow_sticky", underflow, c.exp_uf);
      clr_status = 1;
      step();
      clr_status = 0;
      chk("underflow_cleared", underflow, 0);
    end
    // start threshold: level 3 holds the block in blanking, level 4 releases it
    do_reset();
    for (int n = 1; n <= 3; n++) fifo_q.push_back(8'(n));
    upd();
    en = 1;
    pix_en = 1;
    repeat (12) step();
    chk("wait_line_valid", line_valid, 0);
    chk("wait_frame_valid", frame_valid, 0);
    chk("wait_rd_en", rd_en, 0);
    chk("wait_level", fifo_level, 3);
    fifo_q.push_back(8'd4);
    upd();
    step();
    chk("start_rd_en", rd_en, 1);
    chk("start_line_valid_lag", line_valid, 0);
    step();
    chk("start_line_valid", line_valid, 1);
    chk("start_sof", sof, 1);
    chk("start_pixel", pixel_out, 1);
    step();
    chk("second_sof", sof, 0);
    chk("second_pixel", pixel_out, 2);
    // asynchronous reset mid-line
    nRST = 0;
    #1;
    chk("arst_line_valid", line_valid, 0);
    chk("arst_frame_valid", frame_valid, 0);
    chk("arst_sof", sof, 0);
    chk("arst_pixel", pixel_out, 0);
    chk("arst_rd_en", rd_en, 0);
    #1;
    nRST = 1;
    for (int n = 5; n <= 16; n++) fifo_q.push_back(8'(n));
    upd();
    got_sof = 0;
    for (int t = 0; t < 40 && got_sof == 0; t++) begin
      step();
      if (sof) got_sof = 1;
    end
    chk("post_reset_sof", got_sof, 1);
    chk("post_reset_pixel", pixel_out, 3);
    en = 0;
    pix_en = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
